serial_add_ctrl: RTL

Multi-cycle controller that computes a WIDTH-bit add with carry-in by reusing one narrow SLICE-bit adder across WIDTH/SLICE cycles. It trades latency for area wherever a full-width adder is too costly. Operands enter through a valid/ready request port. Sum and carry-out leave through a valid/ready result port.

---
 rtl/serial_add_pkg.sv | 16 +
 rtl/adder_slice.sv | 15 +
 rtl/serial_add_ctrl.sv | 86 ++++++++
 3 files changed

// File: rtl/serial_add_pkg.sv
// Shared definitions for the slice-serial adder controller: FSM encoding and
// a constant-evaluable clog2 used to size the slice index.
package serial_add_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/adder_slice.sv
// Purely combinational W-bit adder with carry in/out; the one shared datapath
// element that the controller time-multiplexes across the operand.
module adder_slice #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co
);

  assign {co, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};

endmodule

// File: rtl/serial_add_ctrl.sv
// WIDTH-bit add with carry-in computed over WIDTH/SLICE cycles on one SLICE-bit
// adder. Valid/ready on both the request and the result side.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] in_1,
  input  logic [WIDTH-1:0] in_2,
  input  logic             cin,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IW     = (clog2(NSLICE) < 1) ? 1 : clog2(NSLICE);

  if (WIDTH % SLICE != 0) begin : g_bad_slice
    $error("serial_add_ctrl: WIDTH must be a multiple of SLICE");
  end

  // Operands and sum viewed as NSLICE packed slices so idx selects directly.
  logic [NSLICE-1:0][SLICE-1:0] a_q, b_q, sum_q;
  logic [1:0]    state;
  logic [IW-1:0] idx;
  logic          carry_q, cout_q;
  logic [SLICE-1:0] slc_s;
  logic             slc_co;

  adder_slice #(.W(SLICE)) u_slice (
    .a  (a_q[idx]),
    .b  (b_q[idx]),
    .ci (carry_q),
    .s  (slc_s),
    .co (slc_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx     <= '0;
    end else begin
      case (state)
        S_IDLE: if (start_valid) begin
          a_q     <= in_1;
          b_q     <= in_2;
          carry_q <= cin;
          idx     <= '0;
          sum_q   <= '0;
          state   <= S_RUN;
        end
        S_RUN: begin
          sum_q[idx] <= slc_s;
          carry_q    <= slc_co;
          idx        <= idx + 1'b1;
          if (idx == IW'(NSLICE - 1)) begin
            cout_q <= slc_co;
            state  <= S_DONE;
          end
        end
        S_DONE: if (res_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign start_ready = (state == S_IDLE);
  assign res_valid   = (state == S_DONE);
  assign busy        = (state == S_RUN) || (state == S_DONE);
  assign sum         = sum_q;
  assign cout        = cout_q;

endmodule
